// File: rtl/spi_byte_receiver.sv
// SPI mode-0 byte receiver: synchronizes the host's dc/sclk/mosi/cs_n and deserializes MSB-first bytes.
// Latency: raw 8th sclk rise to spi_byte_vld_out = SYNC_STAGES + 1 clk_in edges (+1 for sampling uncertainty).
// Backpressure: none; the consumer must accept every one-cycle valid, which is at least 16 cycles apart.
module spi_byte_receiver #(
    parameter int SYNC_STAGES = 2    // legal range 2..4
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       dc_in,
    input  logic       spi_sclk_in,
    input  logic       spi_mosi_in,
    input  logic       spi_cs_n_in,
    output logic       spi_frame_start_out,
    output logic       spi_byte_vld_out,
    output logic [7:0] spi_byte_data_out,
    output logic       spi_byte_dc_out
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic [SYNC_STAGES-1:0] cs_n_sync;

    logic       s_sclk;
    logic       s_mosi;
    logic       s_dc;
    logic       s_cs_n;
    logic       prev_sclk;
    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       rise;
    logic       cs_fall;
    logic       take_bit;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [2:0] bit_cnt;

    // Reset values match the bus idle state so a clean reset never fakes an edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            dc_sync   <= '0;
            cs_n_sync <= '1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_in};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0],   dc_in};
            cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], spi_cs_n_in};
        end
    end

    assign s_sclk = sclk_sync[SYNC_STAGES-1];
    assign s_mosi = mosi_sync[SYNC_STAGES-1];
    assign s_dc   = dc_sync[SYNC_STAGES-1];
    assign s_cs_n = cs_n_sync[SYNC_STAGES-1];

    // The state register doubles as the previous-cs_n register: IDLE means cs_n was high.
    assign state_d  = s_cs_n ? ST_IDLE : ST_SHIFT;
    assign rise     = s_sclk & ~prev_sclk;
    assign cs_fall  = (state_q == ST_IDLE) & ~s_cs_n;
    assign take_bit = rise & (state_d == ST_SHIFT);
    assign shift_d  = {shift_q[6:0], s_mosi};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            prev_sclk <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            prev_sclk <= s_sclk;
            state_q   <= state_d;
        end
    end

    // Deassertion of cs_n beats a coincident sclk rise: the partial byte is dropped.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shift_q <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (state_d == ST_IDLE) begin
            shift_q <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (take_bit) begin
            shift_q <= shift_d;
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            spi_frame_start_out <= 1'b0;
            spi_byte_vld_out    <= 1'b0;
            spi_byte_data_out   <= 8'h00;
            spi_byte_dc_out     <= 1'b0;
        end else begin
            spi_frame_start_out <= cs_fall;
            spi_byte_vld_out    <= 1'b0;
            if (take_bit && (bit_cnt == 3'd7)) begin
                spi_byte_vld_out  <= 1'b1;
                spi_byte_data_out <= shift_d;
                spi_byte_dc_out   <= s_dc;
            end
        end
    end

endmodule

// File: tb/tb_spi_byte_receiver.sv
// Randomized bench for spi_byte_receiver against a byte-level reference model.
`timescale 1ns/1ps
module tb_spi_byte_receiver;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dc = 1'b0;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic       fs;
    logic       vld;
    logic [7:0] data;
    logic       dc_o;

    spi_byte_receiver #(.SYNC_STAGES(S)) dut (
        .clk_in              (clk),
        .rst_n_in            (rst_n),
        .dc_in               (dc),
        .spi_sclk_in         (sclk),
        .spi_mosi_in         (mosi),
        .spi_cs_n_in         (cs_n),
        .spi_frame_start_out (fs),
        .spi_byte_vld_out    (vld),
        .spi_byte_data_out   (data),
        .spi_byte_dc_out     (dc_o)
    );

    always #2.5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bytes fully clocked in inside a frame, as {dc, data}.
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    logic [7:0] model_data = 8'h00;
    int fs_cnt = 0;
    int hold_err = 0;
    int lat_bad = 0;
    int last_rise_cyc = 0;
    logic [7:0] prev_data = 8'h00;
    logic prev_dc = 1'b0;
    logic prev_rst = 1'b0;

    always @(negedge clk) begin
        if (rst_n && prev_rst) begin
            if (vld) begin
                obs_q.push_back({dc_o, data});
                if ((cyc - last_rise_cyc) > S + 3 || (cyc - last_rise_cyc) < 1) lat_bad++;
            end else if (data !== prev_data || dc_o !== prev_dc) begin
                hold_err++;
            end
            if (fs) fs_cnt++;
        end
        prev_data = data;
        prev_dc   = dc_o;
        prev_rst  = rst_n;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        fs_cnt   = 0;
        hold_err = 0;
        lat_bad  = 0;
    endtask

    task automatic send_bit(input logic b, input int lo, input int hi);
        mosi = b;
        sclk = 1'b0;
        tick(lo);
        sclk = 1'b1;
        last_rise_cyc = cyc;
        tick(hi);
    endtask

    // rnd=0 gives a 5-cycle sclk period (40 MHz against a 200 MHz clock).
    task automatic send_byte(input logic [7:0] d, input logic dcv, input int nbits,
                             input bit rnd, input bit expect_it);
        dc = dcv;
        for (int i = 0; i < nbits; i++) begin
            if (rnd) send_bit(d[7-i], $urandom_range(2, 4), $urandom_range(2, 4));
            else     send_bit(d[7-i], 3, 2);
        end
        if (expect_it && nbits == 8) begin
            exp_q.push_back({dcv, d});
            model_data = d;
        end
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        tick(3);
    endtask

    task automatic frame_end();
        sclk = 1'b0;
        tick(2);
        cs_n = 1'b1;
        tick(6);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        n_cmp++; if (vld !== 1'b0)  begin n_bad++; $display("FAIL reset_vld: got %b want 0", vld); end
        n_cmp++; if (fs !== 1'b0)   begin n_bad++; $display("FAIL reset_fs: got %b want 0", fs); end
        n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data); end
        n_cmp++; if (dc_o !== 1'b0) begin n_bad++; $display("FAIL reset_dc: got %b want 0", dc_o); end
        rst_n = 1'b1;
        model_data = 8'h00;
        tick(4);
    endtask

    task automatic test_single_byte();
        clear_obs();
        frame_begin();
        send_byte(8'hDA, 1'b0, 8, 1'b0, 1'b1);
        frame_end();
        n_cmp++; if (obs_q.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            n_cmp++; if (obs_q[0] !== 9'h0DA) begin n_bad++; $display("FAIL single_byte: got %h want 0da", obs_q[0]); end
        end
        n_cmp++; if (fs_cnt !== 1) begin n_bad++; $display("FAIL single_fs: got %0d want 1", fs_cnt); end
        n_cmp++; if (lat_bad !== 0) begin n_bad++; $display("FAIL single_latency: got %0d late want 0", lat_bad); end
    endtask

    task automatic test_multi_byte();
        clear_obs();
        frame_begin();
        send_byte(8'h2C, 1'b0, 8, 1'b0, 1'b1);
        send_byte(8'hFF, 1'b1, 8, 1'b0, 1'b1);
        send_byte(8'h00, 1'b1, 8, 1'b0, 1'b1);
        frame_end();
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL multi_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL multi_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (fs_cnt !== 1) begin n_bad++; $display("FAIL multi_fs: got %0d want 1", fs_cnt); end
    endtask

    task automatic test_partial_drop();
        clear_obs();
        frame_begin();
        send_byte(8'hA5, 1'b1, 5, 1'b0, 1'b1);
        frame_end();
        frame_begin();
        send_byte(8'h3C, 1'b1, 8, 1'b0, 1'b1);
        frame_end();
        n_cmp++; if (obs_q.size() !== 1) begin n_bad++; $display("FAIL partial_count: got %0d want 1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            n_cmp++; if (obs_q[0] !== 9'h13C) begin n_bad++; $display("FAIL partial_byte: got %h want 13c", obs_q[0]); end
        end
        n_cmp++; if (fs_cnt !== 2) begin n_bad++; $display("FAIL partial_fs: got %0d want 2", fs_cnt); end
    endtask

    task automatic test_reset_mid_byte();
        clear_obs();
        frame_begin();
        send_byte(8'hC3, 1'b1, 4, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (data !== 8'h00 || dc_o !== 1'b0 || vld !== 1'b0)
            begin n_bad++; $display("FAIL midreset_outputs: got data=%h dc=%b vld=%b want 0", data, dc_o, vld); end
        sclk = 1'b0;
        cs_n = 1'b1;
        tick(3);
        rst_n = 1'b1;
        model_data = 8'h00;
        tick(4);
        clear_obs();
        frame_begin();
        send_byte(8'h81, 1'b0, 8, 1'b0, 1'b1);
        frame_end();
        n_cmp++; if (obs_q.size() !== 1) begin n_bad++; $display("FAIL midreset_count: got %0d want 1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            n_cmp++; if (obs_q[0] !== 9'h081) begin n_bad++; $display("FAIL midreset_byte: got %h want 081", obs_q[0]); end
        end
    endtask

    task automatic test_cs_high_sclk();
        clear_obs();
        cs_n = 1'b1;
        send_byte(8'($urandom), 1'b1, 8, 1'b1, 1'b0);
        send_byte(8'($urandom), 1'b0, 8, 1'b1, 1'b0);
        sclk = 1'b0;
        tick(6);
        n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL idle_vld: got %0d pulses want 0", obs_q.size()); end
        n_cmp++; if (fs_cnt !== 0) begin n_bad++; $display("FAIL idle_fs: got %0d want 0", fs_cnt); end
        n_cmp++; if (data !== model_data) begin n_bad++; $display("FAIL idle_data: got %h want %h", data, model_data); end
    endtask

    task automatic test_collision();
        logic [7:0] nxt;
        clear_obs();
        frame_begin();
        send_byte(8'h77, 1'b1, 7, 1'b0, 1'b0);
        mosi = 1'b1;
        sclk = 1'b0;
        tick(3);
        sclk = 1'b1;
        cs_n = 1'b1;
        tick(3);
        sclk = 1'b0;
        tick(6);
        n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL collide_vld: got %0d pulses want 0", obs_q.size()); end
        nxt = 8'($urandom);
        frame_begin();
        send_byte(nxt, 1'b1, 8, 1'b0, 1'b1);
        frame_end();
        n_cmp++; if (obs_q.size() !== 1) begin n_bad++; $display("FAIL collide_next_count: got %0d want 1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            n_cmp++; if (obs_q[0] !== {1'b1, nxt}) begin n_bad++; $display("FAIL collide_next_byte: got %h want %h", obs_q[0], {1'b1, nxt}); end
        end
        n_cmp++; if (fs_cnt !== 2) begin n_bad++; $display("FAIL collide_fs: got %0d want 2", fs_cnt); end
    endtask

    task automatic test_random();
        int frames;
        clear_obs();
        frames = 8;
        for (int f = 0; f < frames; f++) begin
            int nb;
            nb = $urandom_range(1, 4);
            frame_begin();
            for (int b = 0; b < nb; b++)
                send_byte(8'($urandom), 1'($urandom), 8, 1'b1, 1'b1);
            if ($urandom_range(0, 3) == 0)
                send_byte(8'($urandom), 1'($urandom), $urandom_range(1, 7), 1'b1, 1'b1);
            frame_end();
        end
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (fs_cnt !== frames) begin n_bad++; $display("FAIL rand_fs: got %0d want %0d", fs_cnt, frames); end
        n_cmp++; if (hold_err !== 0) begin n_bad++; $display("FAIL rand_hold: got %0d changes without valid want 0", hold_err); end
        n_cmp++; if (lat_bad !== 0) begin n_bad++; $display("FAIL rand_latency: got %0d late want 0", lat_bad); end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_single_byte();
        test_multi_byte();
        test_partial_drop();
        test_reset_mid_byte();
        test_cs_high_sclk();
        test_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
